// File: rtl/mcol_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// Processes COLS_PER_CYCLE columns per clock, from column 0 upward, over a 128-bit working register.
module mcol_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit ENABLE_INV     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a state; in_ready high
  // PROC  | transforming COLS_PER_CYCLE columns per edge
  // DONE  | result held in working register until out_ready
  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  state_t       state;
  logic [1:0]   cnt;
  logic         mode;
  logic [127:0] work;

  logic [1:0]  lane_idx [COLS_PER_CYCLE];
  logic [31:0] lane_in  [COLS_PER_CYCLE];
  logic [31:0] lane_out [COLS_PER_CYCLE];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
            xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
  endfunction

  // Per byte, build the 09/0B/0D/0E multiples from shared x2/x4/x8 terms.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m2, m4, m8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      m2    = xt(s[i]);
      m4    = xt(m2);
      m8    = xt(m4);
      m9[i] = m8 ^ s[i];
      mb[i] = m8 ^ m2 ^ s[i];
      md[i] = m8 ^ m4 ^ s[i];
      me[i] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign lane_idx[j] = cnt + 2'(j);
    assign lane_in[j]  = work[{lane_idx[j], 5'b0} +: 32];
    if (ENABLE_INV) begin : g_inv
      assign lane_out[j] = mode ? mix_inv(lane_in[j]) : mix_fwd(lane_in[j]);
    end else begin : g_fwd
      assign lane_out[j] = mix_fwd(lane_in[j]);
    end
  end

  assign out_state = work;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      mode      <= 1'b0;
      work      <= 128'h0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_state;
            mode     <= in_inv && ENABLE_INV;
            cnt      <= 2'd0;
            state    <= PROC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        PROC: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++)
            work[{lane_idx[j], 5'b0} +: 32] <= lane_out[j];
          cnt <= cnt + STEP;
          if (cnt == LAST_CNT) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcol_iter.sv
// Bench for mcol_iter: four instances (1/2/4 columns per cycle, forward-only),
// a transaction-level model checked every cycle, plus literal vector checks.
module tb_mcol_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_state  [4];
  logic [127:0] out_state [4];

  int checks = 0;
  int errors = 0;

  int nlat [4] = '{4, 2, 1, 4};
  bit einv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  mcol_iter #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));
  mcol_iter #(.COLS_PER_CYCLE(2), .ENABLE_INV(1'b1)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));
  mcol_iter #(.COLS_PER_CYCLE(4), .ENABLE_INV(1'b1)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));
  mcol_iter #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_state(in_state[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_state(out_state[3]), .busy(busy[3]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product; coefficient for row r, input byte c is coef[(c-r) mod 4].
  function automatic logic [127:0] xform(input logic [127:0] st, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = 128'h0;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int c = 0; c < 4; c++)
          acc = acc ^ gmul(coef[(c - r + 4) % 4], st[32*k + 8*(3-c) +: 8]);
        res[32*k + 8*(3-r) +: 8] = acc;
      end
    return res;
  endfunction

  task automatic check(input string nm, input int d, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle / counting PROC edges / done, and the full expected result.
  logic         m_known = 1'b0;
  logic [3:0]   m_idle, m_done, m_zero;
  int           m_cnt [4];
  logic [127:0] m_res [4];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1;
      m_idle  <= 4'hf;
      m_done  <= 4'h0;
      m_zero  <= 4'hf;
    end else if (m_known) begin
      for (int d = 0; d < 4; d++) begin
        if (m_idle[d]) begin
          if (in_valid[d]) begin
            m_idle[d] <= 1'b0;
            m_cnt[d]  <= 0;
            m_res[d]  <= xform(in_state[d], in_inv[d] && einv[d]);
            m_zero[d] <= 1'b0;
          end
        end else if (!m_done[d]) begin
          m_cnt[d] <= m_cnt[d] + 1;
          if (m_cnt[d] + 1 == nlat[d]) m_done[d] <= 1'b1;
        end else if (out_ready[d]) begin
          m_done[d] <= 1'b0;
          m_idle[d] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      for (int d = 0; d < 4; d++) begin
        check("in_ready", d, 128'(in_ready[d]), 128'(m_idle[d]));
        check("out_valid", d, 128'(out_valid[d]), 128'(m_done[d]));
        check("busy", d, 128'(busy[d]), 128'(!m_idle[d]));
        if (m_done[d]) check("out_state", d, out_state[d], m_res[d]);
        else if (m_zero[d] && m_idle[d]) check("out_state_rst", d, out_state[d], 128'h0);
      end
    end
  end

  task automatic do_job(input int d, input logic [127:0] st, input logic inv, input int hold,
                        output logic [127:0] res, output int lat);
    int guard;
    guard = 0;
    res = 128'h0;
    lat = 0;
    while (!in_ready[d] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready[d]) begin
      check("wait_ready_timeout", d, 128'(in_ready[d]), 128'h1);
      return;
    end
    in_valid[d]  = 1'b1;
    in_state[d]  = st;
    in_inv[d]    = inv;
    out_ready[d] = (hold == 0);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_inv[d]   = ~inv;
    in_state[d] = {$urandom, $urandom, $urandom, $urandom};
    while (!out_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid[d]) begin
      check("wait_valid_timeout", d, 128'(out_valid[d]), 128'h1);
      return;
    end
    res = out_state[d];
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'b1;
      check("bp_valid", d, 128'(out_valid[d]), 128'h1);
      check("bp_state", d, out_state[d], res);
      check("bp_ready", d, 128'(in_ready[d]), 128'h0);
      @(posedge clk); #1;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    check("ready_after_done", d, 128'(in_ready[d]), 128'h1);
  endtask

  logic [127:0] r1, r2, st;
  int lat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'h0;
    in_inv    = 4'h0;
    out_ready = 4'hf;
    for (int d = 0; d < 4; d++) in_state[d] = 128'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 0, 128'(in_ready), 128'hf);
    check("rst_busy", 0, 128'(busy), 128'h0);
    check("rst_out_valid", 0, 128'(out_valid), 128'h0);
    check("rst_out_state", 0, out_state[0], 128'h0);

    check("model_fwd", -1, xform(VEC_A, 1'b0), VEC_B);
    check("model_inv", -1, xform(VEC_B, 1'b1), VEC_A);

    do_job(0, VEC_A, 1'b0, 0, r1, lat);
    check("fwd_vec", 0, r1, VEC_B);
    check("lat_c1", 0, 128'(lat), 128'd4);
    do_job(0, VEC_B, 1'b1, 0, r1, lat);
    check("inv_vec", 0, r1, VEC_A);
    do_job(1, VEC_A, 1'b0, 0, r1, lat);
    check("fwd_vec", 1, r1, VEC_B);
    check("lat_c2", 1, 128'(lat), 128'd2);
    do_job(2, VEC_B, 1'b1, 0, r1, lat);
    check("inv_vec", 2, r1, VEC_A);
    check("lat_c4", 2, 128'(lat), 128'd1);

    do_job(0, VEC_A, 1'b0, 10, r1, lat);
    check("bp_result", 0, r1, VEC_B);

    // Reset lands on the second PROC edge.
    in_valid[0] = 1'b1;
    in_state[0] = VEC_A;
    in_inv[0]   = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", 0, 128'(busy[0]), 128'h0);
    check("midrst_state", 0, out_state[0], 128'h0);
    check("midrst_ready", 0, 128'(in_ready[0]), 128'h1);
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_valid", 0, 128'(out_valid[0]), 128'h0);
      @(posedge clk); #1;
    end

    do_job(3, VEC_A, 1'b1, 0, r1, lat);
    check("fwd_only_vec", 3, r1, VEC_B);
    for (int i = 0; i < 5; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      do_job(3, st, 1'b1, 0, r1, lat);
      check("fwd_only_rand", 3, r1, xform(st, 1'b0));
    end

    for (int i = 0; i < 1000; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      do_job(2, st, 1'b0, 0, r1, lat);
      do_job(2, r1, 1'b1, 0, r2, lat);
      check("roundtrip", 2, r2, st);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        do_job(d, st, 1'b0, i % 3, r1, lat);
        do_job(d, r1, 1'b1, 0, r2, lat);
        check("roundtrip", d, r2, st);
      end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcol_iter.md
MCOL_ITER -- requirements
Module: mcol_iter

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, meaning AES state columns processed per clock; legal values 1, 2, 4.
REQ-002 The block SHALL have parameter ENABLE_INV, default 1, meaning 1 = InvMixColumns mode available, 0 = forward-only hardware.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_state/in_inv are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-007 The block SHALL have port in_state, input, 128 bits: state; column k = bits [32k+31:32k], row 0 byte = column bits [31:24], row 3 byte = [7:0].
REQ-008 The block SHALL have port in_inv, input, 1 bit: 1 = InvMixColumns, 0 = MixColumns.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_state holds a finished result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_state.
REQ-011 The block SHALL have port out_state, output, 128 bits: result, same column/row packing as in_state.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, PROC and DONE; in_ready = (state == IDLE), out_valid = (state == DONE).
REQ-014 Accept SHALL occur on an edge with in_valid && in_ready; that edge registers in_state, latches mode (in_inv && ENABLE_INV), clears the column counter and moves the FSM to PROC.
REQ-015 In PROC, each edge SHALL replace COLS_PER_CYCLE columns, starting at column 0 in ascending order, with their transformed values, and advance the counter by COLS_PER_CYCLE.
REQ-016 The counter width SHALL be 2 bits, wrapping modulo 4; on the edge that transforms column 3, the FSM SHALL move to DONE.
REQ-017 Latency SHALL be N = 4/COLS_PER_CYCLE edges from accept to out_valid; out_valid is first high in the cycle after the Nth PROC edge.
REQ-018 Forward mode SHALL apply, per column with bytes s0..s3, matrix rows [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02] over GF(2^8), reduction polynomial 0x11B.
REQ-019 Inverse mode SHALL apply matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E].
REQ-020 With ENABLE_INV = 0, in_inv SHALL be ignored and no inverse logic SHALL be generated.
REQ-021 In DONE, out_state SHALL be held stable while out_ready = 0, for any number of cycles.
REQ-022 An edge in DONE with out_ready = 1 SHALL return the FSM to IDLE; there is no accept on that same edge, so the minimum issue interval is N+2 cycles.
REQ-023 in_valid/in_state SHALL be ignored outside IDLE; in_inv changes after accept SHALL have no effect on the job in flight.
REQ-024 out_state SHALL reflect the working register at all times; it is defined only while out_valid = 1.

Reset
REQ-025 On an edge with rst_n = 0, the block SHALL force state = IDLE, counter = 0, mode = 0 and working register/out_state = 128'h0, giving out_valid = 0 and busy = 0.
REQ-026 in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-027 Reset in PROC or DONE SHALL discard the job in flight; no out_valid pulse SHALL follow the reset.
REQ-028 rst_n = 0 SHALL take priority over every simultaneous handshake event.

Verification
REQ-029 Forward vector: in_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6, in_inv = 0 -> out_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-030 Inverse vector: in_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv = 1 -> out_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6.
REQ-031 Latency sweep: COLS_PER_CYCLE = 1/2/4 with out_ready held 1 -> out_valid first high 4/2/1 edges after accept, for one cycle; in_ready returns the following cycle.
REQ-032 Backpressure: out_ready = 0 for 10 cycles -> out_valid stays 1, out_state is unchanged, in_ready = 0 throughout and a new in_valid is not taken.
REQ-033 Reset mid-job: rst_n = 0 on the 2nd PROC edge with COLS_PER_CYCLE = 1 -> next cycle busy = 0, out_state = 0, in_ready = 1, and no out_valid is seen.
REQ-034 Random round trip: 1000 random states, forward then inverse -> output equals the original state; with ENABLE_INV = 0 and in_inv = 1 -> forward result.
